// File: rtl/logo_pkg.sv
// Shared constants and FSM state encoding for the logo wave scanner.
package logo_pkg;

  localparam int COLS    = 251;
  localparam int ROWS    = 38;
  localparam int ADDR_W  = 10;
  localparam int ROW_TOP = ROWS - 1;
  localparam int IDX_W   = $clog2(ROWS);
  localparam int SHIFT_W = ADDR_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_PRESENT,
    ST_DWELL
  } state_t;

endpackage

// File: rtl/logo_wave_scan_ctrl_if.sv
// ROM address/data and column valid/ready bus between the scanner and its peers.
interface logo_wave_scan_ctrl_if;
  import logo_pkg::*;

  logic [ADDR_W-1:0] rom_addr;
  logic [ROWS-1:0]   rom_data;
  logic [ROWS-1:0]   col_data;
  logic              col_valid;
  logic              col_ready;

  modport master (
    output rom_addr, col_data, col_valid,
    input  rom_data, col_ready
  );

  modport slave (
    input  rom_addr, col_data, col_valid,
    output rom_data, col_ready
  );

endinterface

// File: rtl/logo_wave_shift.sv
// Combinational vertical shift of one column, zero fill; out row k = in row k-shift.
// Row k lives at bit ROW_TOP-k, so a positive shift moves the image toward bit 0.
module logo_wave_shift
  import logo_pkg::*;
(
  input  logic [ROWS-1:0]           rom_data,
  input  logic signed [SHIFT_W-1:0] shift,
  output logic [ROWS-1:0]           col_out
);

  always_comb begin
    int src;
    src     = 0;
    col_out = '0;
    for (int k = 0; k < ROWS; k++) begin
      src = k - int'(shift);
      if (src >= 0 && src < ROWS) begin
        col_out[IDX_W'(ROW_TOP - k)] = rom_data[IDX_W'(ROW_TOP - src)];
      end
    end
  end

endmodule

// File: rtl/logo_wave_scan_ctrl.sv
// Walks logo ROM columns, applies per-column wave shift, presents each over valid/ready
// and holds it DWELL_CYCLES; col_valid stays high with data frozen until col_ready.
module logo_wave_scan_ctrl
  import logo_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int AMP          = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   wave_en,
  logo_wave_scan_ctrl_if.master  bus,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic [7:0]             frame_cnt
);

  localparam int DW_W = $clog2(DWELL_CYCLES) + 1;
  localparam logic [ADDR_W:0]   PERIOD_W   = (ADDR_W + 1)'(4 * AMP);
  localparam logic [ADDR_W:0]   HALF_W     = (ADDR_W + 1)'(2 * AMP);
  localparam logic [ADDR_W:0]   AMP_W      = (ADDR_W + 1)'(AMP);
  localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(COLS - 1);
  localparam logic [DW_W-1:0]   DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ROWS-1:0]     col_data_q, col_data_d;
  logic                col_valid_q, col_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;

  logic [ADDR_W:0]           phase_sum, phase, tri_w;
  logic signed [SHIFT_W-1:0] wave_s;
  logic [ROWS-1:0]           shifted;

  // Triangle wave over 4*AMP columns, recentred to -AMP..+AMP.
  always_comb begin
    phase_sum = {1'b0, rom_addr_q} + {{(ADDR_W - 7){1'b0}}, frame_cnt_q};
    phase     = phase_sum % PERIOD_W;
    tri_w     = (phase < HALF_W) ? phase : (PERIOD_W - phase);
    wave_s    = wave_en ? ($signed({1'b0, tri_w}) - $signed({1'b0, AMP_W})) : '0;
  end

  logo_wave_shift u_shift (
    .rom_data (bus.rom_data),
    .shift    (wave_s),
    .col_out  (shifted)
  );

  always_comb begin
    state_d       = state_q;
    rom_addr_d    = rom_addr_q;
    col_data_d    = col_data_q;
    col_valid_d   = col_valid_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    dwell_d       = dwell_q;
    case (state_q)
      ST_IDLE: begin
        rom_addr_d = '0;
        if (enable) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        col_data_d    = shifted;
        col_valid_d   = 1'b1;
        frame_start_d = (rom_addr_q == '0);
        state_d       = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (col_valid_q && bus.col_ready) begin
          col_valid_d = 1'b0;
          dwell_d     = DWELL_LOAD;
          state_d     = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DW_W'(1);
        end else begin
          if (rom_addr_q == LAST_COL) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
            rom_addr_d   = '0;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
          end
          // Stopping always restarts the next run from column 0.
          if (enable) begin
            state_d = ST_FETCH;
          end else begin
            state_d    = ST_IDLE;
            rom_addr_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rom_addr_q    <= '0;
      col_data_q    <= '0;
      col_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      dwell_q       <= '0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      col_data_q    <= col_data_d;
      col_valid_q   <= col_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      dwell_q       <= dwell_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.col_data  = col_data_q;
  assign bus.col_valid = col_valid_q;
  assign frame_start   = frame_start_q;
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule
